// File: rtl/ber_checker.sv
// Bit-error-rate checker: slices the received sample, finds the reference delay
// by scanning windows of PRBS_LEN symbols, then counts bits and errors once locked.
module ber_checker #(
  parameter int NB_INPUT  = 8,
  parameter int NBF_INPUT = 7,
  parameter int NB_COUNT  = 64,
  parameter int PRBS_LEN  = 511,
  parameter int NB_DELAY  = 9
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic signed [NB_INPUT-1:0] i_rx_sample,
  input  logic                       i_ref_bit,
  input  logic                       i_clear,
  output logic                       o_locked,
  output logic [NB_DELAY-1:0]        o_delay,
  output logic [NB_COUNT-1:0]        o_bit_count,
  output logic [NB_COUNT-1:0]        o_err_count
);
  // The sign bit is the top integer bit; the fractional split never changes it.
  localparam int NBI_INPUT = NB_INPUT - NBF_INPUT;
  localparam int SIGN_BIT  = NBF_INPUT + NBI_INPUT - 1;
  localparam logic [NB_DELAY-1:0] LAST = NB_DELAY'(PRBS_LEN - 1);

  typedef enum logic {ALIGN, LOCKED} state_t;

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [PRBS_LEN-2:0] hist;
  logic [PRBS_LEN-1:0] ref_vec;
  logic                rx_bit, miss, rx_unused;
  state_t              state;
  logic [NB_DELAY-1:0] delay, best_delay, win_cnt, win_err, min_err, win_tot;
  logic [NB_COUNT-1:0] bit_cnt, err_cnt;

  // Assert asynchronously, release two clocks after i_reset rises.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign rx_bit    = i_rx_sample[SIGN_BIT];
  assign rx_unused = ^i_rx_sample[NB_INPUT-2:0];

  // ref_vec[d] is the reference bit presented d strobes ago (d=0: this strobe).
  assign ref_vec = {hist, i_ref_bit};
  assign miss    = rx_bit ^ ref_vec[delay];
  assign win_tot = win_err + NB_DELAY'(miss);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)        hist <= '0;
    else if (i_enable) hist <= ref_vec[PRBS_LEN-2:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALIGN;
      delay      <= '0;
      best_delay <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      min_err    <= '1;
      bit_cnt    <= '0;
      err_cnt    <= '0;
    end else if (i_clear) begin
      state      <= ALIGN;
      delay      <= '0;
      best_delay <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      min_err    <= '1;
      bit_cnt    <= '0;
      err_cnt    <= '0;
    end else if (i_enable) begin
      if (state == ALIGN) begin
        if (win_cnt == LAST) begin
          win_cnt <= '0;
          win_err <= '0;
          if (win_tot == '0) begin
            state <= LOCKED;
          end else if (delay == LAST) begin
            // Scan exhausted: strict less-than keeps the earliest best delay.
            state <= LOCKED;
            if (!(win_tot < min_err)) delay <= best_delay;
          end else begin
            if (win_tot < min_err) begin
              min_err    <= win_tot;
              best_delay <= delay;
            end
            delay <= delay + 1'b1;
          end
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_err <= win_tot;
        end
      end else begin
        if (bit_cnt != '1)         bit_cnt <= bit_cnt + 1'b1;
        if (miss && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign o_locked    = (state == LOCKED);
  assign o_delay     = delay;
  assign o_bit_count = bit_cnt;
  assign o_err_count = err_cnt;
endmodule

// File: tb/tb_ber_checker.sv
// Scoreboard bench for ber_checker with a 31-symbol PRBS5 so full scans stay short.
module tb_ber_checker;
  localparam int PLEN = 31;
  localparam int NBD  = 5;
  localparam int NBC  = 64;

  logic              clock = 1'b0;
  logic              i_reset = 1'b0, i_enable = 1'b0, i_ref_bit = 1'b0, i_clear = 1'b0;
  logic signed [7:0] i_rx_sample = 8'sd64;
  logic              o_locked;
  logic [NBD-1:0]    o_delay;
  logic [NBC-1:0]    o_bit_count, o_err_count;

  always #5 clock = ~clock;

  ber_checker #(.NB_INPUT(8), .NBF_INPUT(7), .NB_COUNT(NBC), .PRBS_LEN(PLEN), .NB_DELAY(NBD)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_rx_sample(i_rx_sample),
    .i_ref_bit(i_ref_bit), .i_clear(i_clear), .o_locked(o_locked), .o_delay(o_delay),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  typedef struct {
    logic           locked;
    logic [NBD-1:0] delay;
    logic [NBC-1:0] bits;
    logic [NBC-1:0] errs;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  chk_ev;
  int    checks = 0, errors = 0;

  logic [4:0] lfsr = 5'h1F;
  bit         txh[64];
  int         rx_dly = 0;

  task automatic expect_out(input string nm, input logic l, input int d, input longint b, input longint er);
    exp_t e;
    e.locked = l; e.delay = NBD'(d); e.bits = NBC'(b); e.errs = NBC'(er);
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> chk_ev;
  endtask

  // Compares the DUT outputs against every expectation queued so far.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (o_locked !== e.locked || o_delay !== e.delay || o_bit_count !== e.bits || o_err_count !== e.errs) begin
          errors++;
          $display("FAIL %s: got locked=%0b delay=%0d bits=%0d errs=%0d, expected locked=%0b delay=%0d bits=%0d errs=%0d",
                   nm, o_locked, o_delay, o_bit_count, o_err_count, e.locked, e.delay, e.bits, e.errs);
        end
      end
    end
  end

  task automatic clear_hist();
    for (int k = 0; k < 64; k++) txh[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // One symbol: per-1 idle clocks, then a strobe clock; rx is ref delayed by rx_dly.
  task automatic strobe(input int per, input bit flip, input bit clr);
    bit r, rx;
    idle(per - 1);
    r    = lfsr[4];
    lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    rx   = (rx_dly == 0) ? r : txh[rx_dly-1];
    rx   = rx ^ flip;
    i_ref_bit   = r;
    i_rx_sample = rx ? -8'sd64 : 8'sd64;
    i_enable    = 1'b1;
    i_clear     = clr;
    @(posedge clock); #1;
    i_enable = 1'b0;
    i_clear  = 1'b0;
    for (int k = 63; k > 0; k--) txh[k] = txh[k-1];
    txh[0] = r;
  endtask

  initial begin
    idle(3);
    for (int i = 0; i < 4; i++) begin
      strobe(4, 1'b0, 1'b0);
      expect_out("reset_hold", 1'b0, 0, 0, 0);
    end
    clear_hist();
    i_reset = 1'b1;
    idle(4);

    // Clean link, rx delayed 5: windows for delays 0..4 fail, delay 5 is perfect.
    rx_dly = 5;
    for (int n = 1; n <= 6*PLEN; n++) begin
      strobe(4, 1'b0, 1'b0);
      if (n == 3*PLEN)     expect_out("align_scan_delay3", 1'b0, 3, 0, 0);
      if (n == 6*PLEN - 1) expect_out("clean_prelock", 1'b0, 5, 0, 0);
    end
    expect_out("clean_lock", 1'b1, 5, 0, 0);
    for (int n = 1; n <= 50; n++) strobe(4, 1'b0, 1'b0);
    expect_out("clean_count", 1'b1, 5, 50, 0);

    // Clear on a strobe: the strobe is not counted.
    strobe(4, 1'b0, 1'b1);
    expect_out("clear_vs_strobe", 1'b0, 0, 0, 0);
    for (int n = 1; n <= 6*PLEN; n++) begin
      strobe(4, 1'b0, 1'b0);
      if (n == 6*PLEN - 1) expect_out("relock_prelock", 1'b0, 5, 0, 0);
    end
    expect_out("relock", 1'b1, 5, 0, 0);

    // Error injection: every 100th sample inverted over 10000 strobes.
    for (int n = 1; n <= 10000; n++) begin
      strobe(2, (n % 100) == 0, 1'b0);
      if (n == 150) expect_out("inject_partial", 1'b1, 5, 150, 1);
    end
    expect_out("inject_total", 1'b1, 5, 10000, 100);

    // Async reset mid-scan at delay 3.
    strobe(2, 1'b0, 1'b1);
    for (int n = 1; n <= 3*PLEN + 5; n++) strobe(2, 1'b0, 1'b0);
    expect_out("mid_scan_delay3", 1'b0, 3, 0, 0);
    #2;
    i_reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 0, 0, 0);
    idle(3);
    clear_hist();
    i_reset = 1'b1;
    idle(4);

    // No perfect delay: rx delayed 7 with every 20th bit flipped, so each
    // 31-symbol window at delay 7 keeps 1-2 errors and the full scan runs.
    rx_dly = 7;
    for (int n = 1; n <= PLEN*PLEN; n++) begin
      strobe(1, (n % 20) == 0, 1'b0);
      if (n == PLEN)          expect_out("restart_delay1", 1'b0, 1, 0, 0);
      if (n == PLEN*PLEN - 1) expect_out("scan_last_window", 1'b0, PLEN - 1, 0, 0);
    end
    expect_out("scan_lock_best", 1'b1, 7, 0, 0);
    for (int n = PLEN*PLEN + 1; n <= PLEN*PLEN + 10; n++) strobe(1, (n % 20) == 0, 1'b0);
    expect_out("scan_count", 1'b1, 7, 10, 0);

    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 SHALL have parameter NB_INPUT, default 8, meaning width of the signed received sample.
REQ-002 SHALL have parameter NBF_INPUT, default 7, meaning fractional bits of the received sample; it does not affect the decision.
REQ-003 SHALL have parameter NB_COUNT, default 64, meaning width of the bit and error counters.
REQ-004 SHALL have parameter PRBS_LEN, default 511, meaning reference period and alignment window length in symbols.
REQ-005 SHALL have parameter NB_DELAY, default 9, meaning width of the delay index, with 2^NB_DELAY > PRBS_LEN.
REQ-006 SHALL have port clock, input, 1 bit: the single system clock, running at the oversampled rate T/4.
REQ-007 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_enable, input, 1 bit: symbol strobe, high for one clock per symbol period T.
REQ-009 SHALL have port i_rx_sample, input, NB_INPUT bits, signed: downsampled filter output.
REQ-010 SHALL have port i_ref_bit, input, 1 bit: transmitted PRBS bit, sampled on the same strobe.
REQ-011 SHALL have port i_clear, input, 1 bit: synchronous restart of alignment and counters.
REQ-012 SHALL have port o_locked, output, 1 bit: high once an alignment delay has been selected.
REQ-013 SHALL have port o_delay, output, NB_DELAY bits: the selected (or currently scanned) delay.
REQ-014 SHALL have port o_bit_count, output, NB_COUNT bits: symbols compared since lock.
REQ-015 SHALL have port o_err_count, output, NB_COUNT bits: errors counted since lock.

Function
REQ-016 SHALL slice the hard decision as rx_bit = MSB of i_rx_sample (negative sample -> 1).
REQ-017 SHALL update state, buffers and counters only on rising clock edges where i_enable=1; with i_enable=0, all registers hold.
REQ-018 SHALL keep a PRBS_LEN-deep reference history so that ref(d) = i_ref_bit presented d strobes earlier, d = 0..PRBS_LEN-1 (d=0 is the current strobe); history is all zero after reset.
REQ-019 SHALL implement FSM states ALIGN and LOCKED; reset and i_clear enter ALIGN with delay=0, window count=0, window errors=0, min_err=all ones, best_delay=0.
REQ-020 In ALIGN, each strobe SHALL compare rx_bit with ref(delay), accumulate the mismatches into window errors, and increment the window count.
REQ-021 On the PRBS_LEN-th strobe of a window, window errors including the current strobe SHALL be evaluated as follows.
- If the total is 0: go to LOCKED with o_delay=delay.
- Else if the total < min_err: set min_err=total and best_delay=delay.
- Then delay increments and the window restarts.
REQ-022 After the window for delay=PRBS_LEN-1 completes without a zero-error window, the FSM SHALL go to LOCKED with o_delay=best_delay; ties resolve to the smallest delay (strict less-than).
REQ-023 In ALIGN, o_delay SHALL show the delay being scanned, and o_bit_count and o_err_count SHALL be 0.
REQ-024 In LOCKED, each strobe SHALL increment o_bit_count and add (rx_bit XOR ref(o_delay)) to o_err_count; the first counted strobe is the one after the lock transition.
REQ-025 Both counters SHALL saturate at all ones, with no wrap-around.
REQ-026 o_locked SHALL be 1 exactly while the FSM is in LOCKED, registered, and SHALL rise on the edge that commits the lock.
REQ-027 i_clear SHALL act regardless of i_enable and SHALL take priority over a simultaneous strobe, whose comparison is discarded; the history buffer is not cleared.
REQ-028 Reset asserted mid-window or while LOCKED SHALL abort immediately; no partial results are kept.

Reset
REQ-029 While i_reset=0, outputs SHALL be o_locked=0, o_delay=0, o_bit_count=0, o_err_count=0, the FSM SHALL be in ALIGN, and the history SHALL be zero.
REQ-030 Reset release SHALL be synchronized internally; the first strobe evaluated is the first one after release.

Verification
REQ-031 Reset: hold i_reset=0 with strobes toggling -> all outputs 0 and o_locked=0 throughout.
REQ-032 Clean link: rx = ref delayed 5 symbols, i_enable every 4th clock -> o_locked rises on strobe 6*511=3066 with o_delay=5; then o_err_count=0 and o_bit_count increments by 1 per strobe.
REQ-033 Error injection: after lock, invert every 100th rx sample over 10000 strobes -> o_err_count=100 and o_bit_count=10000.
REQ-034 No perfect delay: rx = ref delayed 7 with every 50th bit flipped -> full scan of 511 windows, lock with o_delay=7, o_locked high after 511*511 strobes.
REQ-035 Clear vs strobe: assert i_clear on a strobe cycle while LOCKED -> next cycle o_locked=0, o_delay=0, counters 0; the strobe is not counted.
REQ-036 Async reset mid-scan at delay=3 -> outputs go to 0 without waiting for a clock edge; after release, alignment restarts at delay 0.
